uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among N_REQ byte-stream requesters.
- Arbitration is round-robin and packet-atomic: a granted requester keeps the transmitter until it sends a byte flagged last.
- Drives the transmitter's byte/valid/start inputs and consumes its one-cycle done pulse.
- Includes a watchdog that recovers if done never arrives.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among N_REQ byte-stream requesters. Arbitration
// is round-robin and packet-atomic: once a requester is granted it owns the
// transmitter until a byte it sent with its "last" flag has been transmitted.
// A watchdog aborts a byte whose done pulse never arrives. The packet is then
// closed, and the rest of it competes again as a new packet.
//
// Parameters
//   N_REQ           number of requesters (2..8)
//   TIMEOUT_CYCLES  cycles to wait for done_tx_i after a start before aborting
//
// Ports
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   req_data_i     byte from requester i in bits [8i+7:8i]
//   req_vld_i      requester i presents a byte
//   req_last_i     requester i's byte is the last byte of its packet
//   req_rdy_o      requester i's byte is accepted this cycle (combinational)
//   byte_tx_o      byte to the transmitter
//   byte_tx_vld_o  one-cycle pulse: transmitter latches byte_tx_o
//   do_tx_o        one-cycle pulse: transmitter starts a frame
//   done_tx_i      one-cycle pulse from the transmitter at the end of the stop bit
//   grant_o        one-hot owner of the transmitter; zero when idle
//   busy_o         a packet is in progress
//   tx_timeout_o   one-cycle pulse when the watchdog aborts a byte
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_vld_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_rdy_o,
  output logic [7:0]         byte_tx_o,
  output logic               byte_tx_vld_o,
  output logic               do_tx_o,
  input  logic               done_tx_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               tx_timeout_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  // The counter is cleared on the start edge and counts once per WAIT cycle,
  // so reaching TIMEOUT_CYCLES-1 puts the abort pulse TIMEOUT_CYCLES cycles
  // after the do_tx_o pulse.
  localparam logic [WW-1:0] WD_EXPIRE = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WD_MAX    = WW'(TIMEOUT_CYCLES);

  localparam logic [1:0] ST_ARB  = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]    state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] gidx_q;     // index of the current owner
  logic          last_q;     // byte in flight closes the packet
  logic [WW-1:0] wd_q;

  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] next_ptr;
  logic          accept;

  // ---------------------------------------------------------------------------
  // Round-robin search. Candidates are visited from the farthest offset down to
  // rr_ptr itself, so the last hit is the first valid requester at or after
  // rr_ptr going upwards with wrap-around.
  // ---------------------------------------------------------------------------
  always_comb begin : find_winner
    int            cand;
    logic [IW-1:0] cand_idx;
    // NOTE: every combinational output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr_q) + k) % N_REQ;
      cand_idx = IW'(cand);
      if (req_vld_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Search origin after the current owner's packet ends.
  assign next_ptr = (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;

  // Only the owner can be ready, and only while the arbiter is in SEND.
  always_comb begin
    req_rdy_o = '0;
    if (state_q == ST_SEND) begin
      req_rdy_o[gidx_q] = req_vld_i[gidx_q];
    end
  end

  assign accept = (state_q == ST_SEND) && req_vld_i[gidx_q];

  // ---------------------------------------------------------------------------
  // Control and output registers. The transmitter shares rst_i, so a reset in
  // any state simply drops the handshake in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state always uses non-blocking assignments, so every
      // register in this block sees the pre-edge value of every other one.
      state_q       <= ST_ARB;
      rr_ptr_q      <= '0;
      gidx_q        <= '0;
      last_q        <= 1'b0;
      wd_q          <= '0;
      grant_o       <= '0;
      busy_o        <= 1'b0;
      byte_tx_o     <= 8'h00;
      byte_tx_vld_o <= 1'b0;
      do_tx_o       <= 1'b0;
      tx_timeout_o  <= 1'b0;
    end else begin
      // Pulses are high for exactly one cycle unless re-asserted below.
      byte_tx_vld_o <= 1'b0;
      do_tx_o       <= 1'b0;
      tx_timeout_o  <= 1'b0;

      case (state_q)
        ST_ARB: begin
          if (win_found) begin
            gidx_q  <= win_idx;
            grant_o <= N_REQ'(1) << win_idx;
            busy_o  <= 1'b1;
            state_q <= ST_SEND;
          end
        end

        ST_SEND: begin
          // A stalled owner keeps the grant; nobody else is served meanwhile.
          if (accept) begin
            byte_tx_o     <= req_data_i[8*gidx_q +: 8];
            byte_tx_vld_o <= 1'b1;
            do_tx_o       <= 1'b1;
            last_q        <= req_last_i[gidx_q];
            wd_q          <= '0;
            state_q       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (wd_q != WD_MAX) begin
            wd_q <= wd_q + 1'b1;
          end
          // done has priority over an expiry in the same cycle.
          if (done_tx_i) begin
            if (last_q) begin
              rr_ptr_q <= next_ptr;
              grant_o  <= '0;
              busy_o   <= 1'b0;
              state_q  <= ST_ARB;
            end else begin
              state_q  <= ST_SEND;
            end
          end else if (wd_q == WD_EXPIRE) begin
            tx_timeout_o <= 1'b1;
            rr_ptr_q     <= next_ptr;
            grant_o      <= '0;
            busy_o       <= 1'b0;
            state_q      <= ST_ARB;
          end
        end

        default: begin
          state_q <= ST_ARB;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter. Requesters are byte queues and the
// transmitter is a responder that returns done a programmable number of cycles
// after each start. A transaction-level model predicts every output each cycle.
// Directed scenarios pin the model with hand-computed byte orders, grants and
// cycle distances.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 24;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_vld_i  = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_rdy_o;
  logic [7:0]     byte_tx_o;
  logic           byte_tx_vld_o;
  logic           do_tx_o;
  logic           done_tx_i = 1'b0;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           tx_timeout_o;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .req_data_i    (req_data_i),
    .req_vld_i     (req_vld_i),
    .req_last_i    (req_last_i),
    .req_rdy_o     (req_rdy_o),
    .byte_tx_o     (byte_tx_o),
    .byte_tx_vld_o (byte_tx_vld_o),
    .do_tx_o       (do_tx_o),
    .done_tx_i     (done_tx_i),
    .grant_o       (grant_o),
    .busy_o        (busy_o),
    .tx_timeout_o  (tx_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // ---------------------------------------------------------------------------
  // Requester sources
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] d;
    bit         last;
    int         gap;   // cycles the byte is withheld once it reaches the front
  } src_t;

  src_t     src_q[N][$];
  int       hold[N];
  logic [N-1:0] acc = '0;

  task automatic push(input int r, input logic [7:0] d, input bit l, input int gap);
    src_t e;
    e.d = d; e.last = l; e.gap = gap;
    if (src_q[r].size() == 0) hold[r] = gap;
    src_q[r].push_back(e);
  endtask

  task automatic clear_sources();
    for (int r = 0; r < N; r++) begin
      src_q[r].delete();
      hold[r] = 0;
    end
  endtask

  function automatic bit all_empty();
    for (int r = 0; r < N; r++) if (src_q[r].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk_i) acc = req_vld_i & req_rdy_o;

  always @(posedge clk_i) begin
    #1;
    for (int r = 0; r < N; r++) begin
      if (acc[r] && src_q[r].size() > 0) begin
        void'(src_q[r].pop_front());
        if (src_q[r].size() > 0) hold[r] = src_q[r][0].gap;
      end
      if (hold[r] > 0) begin
        hold[r]--;
        req_vld_i[r] = 1'b0;
      end else if (src_q[r].size() > 0) begin
        req_vld_i[r]         = 1'b1;
        req_data_i[8*r +: 8] = src_q[r][0].d;
        req_last_i[r]        = src_q[r][0].last;
      end else begin
        req_vld_i[r]  = 1'b0;
        req_last_i[r] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter responder
  // ---------------------------------------------------------------------------
  int done_delay  = 5;
  bit drop_mode   = 1'b0;
  bit rand_resp   = 1'b0;
  bit spurious_en = 1'b0;
  bit armed       = 1'b0;
  int cnt         = 0;

  always @(posedge clk_i) begin
    #1;
    done_tx_i = 1'b0;
    if (rst_i) begin
      armed = 1'b0;
    end else if (do_tx_o) begin
      if (drop_mode || (rand_resp && $urandom_range(0, 11) == 0)) begin
        armed = 1'b0;
      end else begin
        armed = 1'b1;
        cnt   = rand_resp ? int'($urandom_range(1, 8)) : done_delay;
      end
    end else if (armed) begin
      cnt--;
      if (cnt == 0) begin
        done_tx_i = 1'b1;
        armed     = 1'b0;
      end
    end else if (spurious_en && $urandom_range(0, 63) == 0) begin
      done_tx_i = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: who owns the transmitter, whether a byte is in flight and
  // how long it has been in flight. e_* are the expected registered outputs.
  // ---------------------------------------------------------------------------
  int         m_owner   = -1;
  int         m_ptr     = 0;
  bit         m_wait    = 1'b0;
  bit         m_last    = 1'b0;
  int         m_elapsed = 0;
  logic [7:0] e_byte    = 8'h00;
  bit         e_start   = 1'b0;
  bit         e_to      = 1'b0;

  task automatic m_end_packet();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_wait  = 1'b0;
  endtask

  always @(posedge clk_i) begin
    e_start = 1'b0;
    e_to    = 1'b0;
    if (rst_i) begin
      m_owner = -1; m_ptr = 0; m_wait = 1'b0; m_last = 1'b0;
      m_elapsed = 0; e_byte = 8'h00;
    end else if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req_vld_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
    end else if (!m_wait) begin
      if (req_vld_i[m_owner]) begin
        e_byte    = req_data_i[8*m_owner +: 8];
        e_start   = 1'b1;
        m_last    = req_last_i[m_owner];
        m_wait    = 1'b1;
        m_elapsed = 0;
      end
    end else begin
      m_elapsed++;
      if (done_tx_i) begin
        m_wait = 1'b0;
        if (m_last) m_end_packet();
      end else if (m_elapsed == TO) begin
        e_to = 1'b1;
        m_end_packet();
      end
    end
    started = 1'b1;
  end

  always @(negedge clk_i) begin : compare
    logic [N-1:0] eg;
    logic [N-1:0] er;
    if (started) begin
      eg = '0;
      er = '0;
      if (m_owner >= 0) begin
        eg[m_owner] = 1'b1;
        if (!m_wait) er[m_owner] = req_vld_i[m_owner];
      end
      check("grant",    grant_o,       eg);
      check("busy",     busy_o,        m_owner >= 0);
      check("rdy",      req_rdy_o,     er);
      check("do_tx",    do_tx_o,       e_start);
      check("byte_vld", byte_tx_vld_o, e_start);
      check("byte",     byte_tx_o,     e_byte);
      check("timeout",  tx_timeout_o,  e_to);
    end
  end

  // ---------------------------------------------------------------------------
  // Event log of what the DUT actually did, for the directed expectations.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [7:0] b;
    logic [N-1:0] g;
  } ev_t;

  ev_t tx_log[$];
  int  to_log[$];

  always @(negedge clk_i) begin
    ev_t e;
    if (started && do_tx_o === 1'b1) begin
      e.cyc = cyc; e.b = byte_tx_o; e.g = grant_o;
      tx_log.push_back(e);
    end
    if (started && tx_timeout_o === 1'b1) to_log.push_back(cyc);
  end

  task automatic clear_logs();
    tx_log.delete();
    to_log.delete();
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while (quiet < 2 && n < budget) begin
      @(negedge clk_i);
      n++;
      if (!busy_o && !armed && all_empty() && req_vld_i == '0) quiet++;
      else quiet = 0;
    end
    check({tag, "_idle"}, quiet >= 2, 1);
  endtask

  task automatic check_ev(input string tag, input int k, input logic [7:0] b, input logic [N-1:0] g);
    if (k < tx_log.size()) begin
      check({tag, "_byte"},  tx_log[k].b, b);
      check({tag, "_grant"}, tx_log[k].g, g);
    end else begin
      check({tag, "_missing"}, tx_log.size(), k + 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    clear_sources();
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int t_push;
    int n;
    int len;
    for (int r = 0; r < N; r++) hold[r] = 0;

    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_grant", grant_o, 4'b0000);
    check("rst_busy",  busy_o, 0);
    check("rst_byte",  byte_tx_o, 8'h00);
    rst_i = 1'b0;

    // Single request, three-byte packet from requester 2, done 20 cycles on.
    clear_logs();
    done_delay = 20;
    @(negedge clk_i);
    t_push = cyc;
    push(2, 8'hA1, 0, 0);
    push(2, 8'hA2, 0, 0);
    push(2, 8'hA3, 1, 0);
    wait_idle(400, "t1");
    check("t1_count", tx_log.size(), 3);
    check_ev("t1_0", 0, 8'hA1, 4'b0100);
    check_ev("t1_1", 1, 8'hA2, 4'b0100);
    check_ev("t1_2", 2, 8'hA3, 4'b0100);
    if (tx_log.size() == 3) begin
      check("t1_latency", tx_log[0].cyc - t_push, 3);
      check("t1_gap01",   tx_log[1].cyc - tx_log[0].cyc, 22);
      check("t1_gap12",   tx_log[2].cyc - tx_log[1].cyc, 22);
    end

    // Search now starts at 3: requester 3 beats requester 0.
    clear_logs();
    done_delay = 4;
    @(negedge clk_i);
    push(0, 8'h31, 1, 0);
    push(3, 8'h33, 1, 0);
    wait_idle(200, "t1b");
    check("t1b_count", tx_log.size(), 2);
    check_ev("t1b_0", 0, 8'h33, 4'b1000);
    check_ev("t1b_1", 1, 8'h31, 4'b0001);

    // All four continuously valid, single-byte packets: strictly cyclic order.
    do_reset();
    clear_logs();
    done_delay = 5;
    @(negedge clk_i);
    for (int rep = 0; rep < 3; rep++)
      for (int r = 0; r < N; r++) push(r, 8'h10 + 8'(r), 1, 0);
    wait_idle(600, "t2");
    check("t2_count", tx_log.size(), 12);
    for (int k = 0; k < 12; k++)
      check_ev("t2", k, 8'h10 + 8'(k % 4), 4'(1 << (k % 4)));

    // Packet atomicity: requester 1 waits for all four bytes of requester 0.
    clear_logs();
    done_delay = 6;
    @(negedge clk_i);
    push(0, 8'h20, 0, 0);
    push(0, 8'h21, 0, 0);
    push(0, 8'h22, 0, 0);
    push(0, 8'h23, 1, 0);
    @(negedge clk_i);
    push(1, 8'h30, 1, 0);
    wait_idle(400, "t3");
    check("t3_count", tx_log.size(), 5);
    check_ev("t3_0", 0, 8'h20, 4'b0001);
    check_ev("t3_1", 1, 8'h21, 4'b0001);
    check_ev("t3_2", 2, 8'h22, 4'b0001);
    check_ev("t3_3", 3, 8'h23, 4'b0001);
    check_ev("t3_4", 4, 8'h30, 4'b0010);

    // Mid-packet stall: requester 3 withholds its second byte for 50 cycles.
    clear_logs();
    done_delay = 10;
    @(negedge clk_i);
    push(3, 8'h40, 0, 0);
    push(3, 8'h41, 0, 50);
    push(3, 8'h42, 1, 0);
    push(0, 8'h50, 1, 0);
    wait_idle(500, "t4");
    check("t4_count", tx_log.size(), 4);
    check_ev("t4_0", 0, 8'h40, 4'b1000);
    check_ev("t4_1", 1, 8'h41, 4'b1000);
    check_ev("t4_2", 2, 8'h42, 4'b1000);
    check_ev("t4_3", 3, 8'h50, 4'b0001);
    if (tx_log.size() == 4) begin
      check("t4_stall_gap", tx_log[1].cyc - tx_log[0].cyc, 51);
      check("t4_next_gap",  tx_log[2].cyc - tx_log[1].cyc, 12);
    end

    // Watchdog: done never returns. Every byte times out TO cycles after its
    // start; the rest of requester 1's packet comes back as a new packet.
    clear_logs();
    drop_mode = 1'b1;
    @(negedge clk_i);
    push(1, 8'h60, 0, 0);
    push(1, 8'h63, 1, 0);
    push(2, 8'h61, 1, 0);
    wait_idle(400, "t5");
    drop_mode = 1'b0;
    check("t5_count",    tx_log.size(), 3);
    check("t5_to_count", to_log.size(), 3);
    check_ev("t5_0", 0, 8'h60, 4'b0010);
    check_ev("t5_1", 1, 8'h61, 4'b0100);
    check_ev("t5_2", 2, 8'h63, 4'b0010);
    if (tx_log.size() == 3 && to_log.size() == 3) begin
      for (int k = 0; k < 3; k++) check("t5_to_delay", to_log[k] - tx_log[k].cyc, TO);
      check("t5_regrant", tx_log[1].cyc - to_log[0], 2);
    end

    // done on the expiry cycle wins: no timeout pulse.
    clear_logs();
    done_delay = TO - 1;
    @(negedge clk_i);
    push(3, 8'h62, 1, 0);
    wait_idle(200, "t5b");
    check("t5b_count", tx_log.size(), 1);
    check("t5b_no_to", to_log.size(), 0);
    check_ev("t5b_0", 0, 8'h62, 4'b1000);

    // Reset while waiting for done mid-packet.
    clear_logs();
    done_delay = 20;
    @(negedge clk_i);
    push(2, 8'h70, 0, 0);
    push(2, 8'h71, 1, 0);
    n = 0;
    while (tx_log.size() == 0 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_started", tx_log.size() > 0, 1);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b1;
    clear_sources();
    @(negedge clk_i);
    check("t6_grant",   grant_o, 4'b0000);
    check("t6_busy",    busy_o, 0);
    check("t6_do_tx",   do_tx_o, 0);
    check("t6_bvld",    byte_tx_vld_o, 0);
    check("t6_timeout", tx_timeout_o, 0);
    rst_i = 1'b0;
    clear_logs();
    done_delay = 4;
    @(negedge clk_i);
    for (int r = 0; r < N; r++) push(r, 8'h80 + 8'(r), 1, 0);
    wait_idle(300, "t6");
    check("t6_count", tx_log.size(), 4);
    check_ev("t6_0", 0, 8'h80, 4'b0001);

    // Random traffic: random packets, stalls, done delays, dropped dones and
    // stray done pulses, all checked cycle by cycle against the model.
    rand_resp   = 1'b1;
    spurious_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_i);
      for (int r = 0; r < N; r++) begin
        if (src_q[r].size() == 0 && $urandom_range(0, 9) == 0) begin
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++)
            push(r, 8'($urandom), b == len - 1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
        end
      end
    end
    spurious_en = 1'b0;
    wait_idle(2000, "rand");

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1);
  end

endmodule
